arcade_input_conditioner: RTL and testbench



---
 rtl/arcade_input_pkg.sv | 90 +++++++++
 rtl/coin_shaper.sv | 132 +++++++++++++
 rtl/arcade_input_conditioner.sv | 151 +++++++++++++++
 tb/tb_arcade_input_conditioner.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg
// Shared constants and types for the System 1 input conditioner:
//   - PS/2 scan codes (arrow keys match on the low 8 bits only)
//   - MiSTer joystick bit indices
//   - coin shaper FSM state encoding
//   - bit positions inside the active-low INP bytes
package arcade_input_pkg;

  // Arrow keys: bit [8] (extended prefix) is ignored when matching
  localparam logic [7:0] PS2_UP    = 8'h75;
  localparam logic [7:0] PS2_DOWN  = 8'h72;
  localparam logic [7:0] PS2_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_RIGHT = 8'h74;

  // Exact 9-bit codes
  localparam logic [8:0] PS2_T1    = 9'h029;
  localparam logic [8:0] PS2_T2    = 9'h014;
  localparam logic [8:0] PS2_F1    = 9'h005;
  localparam logic [8:0] PS2_F2    = 9'h006;
  localparam logic [8:0] PS2_ST1   = 9'h016;
  localparam logic [8:0] PS2_ST2   = 9'h01E;
  localparam logic [8:0] PS2_COIN1 = 9'h02E;
  localparam logic [8:0] PS2_COIN2 = 9'h036;
  localparam logic [8:0] PS2_L2    = 9'h023;
  localparam logic [8:0] PS2_R2    = 9'h034;
  localparam logic [8:0] PS2_T1_2  = 9'h01C;
  localparam logic [8:0] PS2_T2_2  = 9'h01B;

  // Joystick word bit indices
  localparam int JOY_R    = 0;
  localparam int JOY_L    = 1;
  localparam int JOY_T1   = 4;
  localparam int JOY_T2   = 5;
  localparam int JOY_ST1  = 6;
  localparam int JOY_ST2  = 7;
  localparam int JOY_COIN = 8;

  // INP byte bit positions (bytes are active-low)
  localparam int INP_T1   = 1;
  localparam int INP_T2   = 2;
  localparam int INP_R    = 6;
  localparam int INP_L    = 7;
  localparam int INP_COIN = 0;
  localparam int INP_ST1  = 4;
  localparam int INP_ST2  = 5;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP   = 2'd2
  } coin_st_t;

  typedef struct packed {
    logic l;
    logic r;
    logic t2;
    logic t1;
  } player_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic t1;
    logic t2;
    logic f1;
    logic f2;
    logic st1;
    logic st2;
    logic coin1;
    logic coin2;
    logic l2;
    logic r2;
    logic t1_2;
    logic t2_2;
  } keys_t;

  // Active-low player byte in the System 1 layout
  function automatic logic [7:0] player_byte(input player_t p);
    logic [7:0] b;
    b         = 8'hFF;
    b[INP_L]  = ~p.l;
    b[INP_R]  = ~p.r;
    b[INP_T2] = ~p.t2;
    b[INP_T1] = ~p.t1;
    return b;
  endfunction

endpackage

// File: rtl/coin_shaper.sv
// coin_shaper
// Turns coin request edges into coin pulses of COIN_MS ms followed by at
// least GAP_MS ms of inactivity. Up to three further edges are queued.
//
// Ports:
//   clk_sys  in   system clock
//   reset    in   asynchronous active-high reset
//   req      in   coin request level (edge-detected internally)
//   coin     out  coin asserted (high for exactly COIN_MS*CLK_KHZ cycles)
//   busy     out  FSM not idle or requests pending
//
// state      | meaning
// -----------+------------------------------------------------------
// COIN_IDLE  | no pulse in progress; starts one on pending or new edge
// COIN_PULSE | coin asserted, counting COIN_MS ticks
// COIN_GAP   | coin released, counting GAP_MS ticks
module coin_shaper
  import arcade_input_pkg::*;
#(
  parameter int CLK_KHZ = 48000,
  parameter int COIN_MS = 50,
  parameter int GAP_MS  = 80
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req,
  output logic coin,
  output logic busy
);

  localparam int MS_MAX = (COIN_MS > GAP_MS) ? COIN_MS : GAP_MS;
  localparam int PW     = $clog2(CLK_KHZ + 1);
  localparam int MW     = $clog2(MS_MAX + 1);

  localparam logic [PW-1:0] PRE_TC  = PW'(CLK_KHZ - 1);
  localparam logic [MW-1:0] MS_COIN = MW'(COIN_MS - 1);
  localparam logic [MW-1:0] MS_GAP  = MW'(GAP_MS - 1);

  coin_st_t      st_q, st_nxt;
  logic [PW-1:0] presc_q, presc_nxt;
  logic [MW-1:0] ms_q, ms_nxt;
  logic [1:0]    pend_q, pend_nxt;
  logic          req_q;
  logic          rise;
  logic          tick;
  logic          start_ok;
  logic          take;

  assign rise     = req & ~req_q;
  assign tick     = (presc_q == PRE_TC);
  // A fresh edge can start a pulse directly without first landing in pending
  assign start_ok = (pend_q != 2'd0) | rise;

  always_comb begin
    st_nxt    = st_q;
    ms_nxt    = ms_q;
    presc_nxt = tick ? '0 : presc_q + 1'b1;
    take      = 1'b0;
    case (st_q)
      COIN_IDLE: begin
        presc_nxt = '0;
        if (start_ok) begin
          st_nxt = COIN_PULSE;
          ms_nxt = MS_COIN;
          take   = 1'b1;
        end
      end
      COIN_PULSE: begin
        if (tick) begin
          if (ms_q == '0) begin
            st_nxt = COIN_GAP;
            ms_nxt = MS_GAP;
          end else begin
            ms_nxt = ms_q - 1'b1;
          end
        end
      end
      COIN_GAP: begin
        if (tick) begin
          if (ms_q == '0) begin
            // IDLE is passed through in zero time when more coins are due,
            // so back-to-back pulses are spaced by exactly the gap.
            if (start_ok) begin
              st_nxt = COIN_PULSE;
              ms_nxt = MS_COIN;
              take   = 1'b1;
            end else begin
              st_nxt = COIN_IDLE;
              ms_nxt = '0;
            end
          end else begin
            ms_nxt = ms_q - 1'b1;
          end
        end
      end
      default: begin
        st_nxt    = COIN_IDLE;
        ms_nxt    = '0;
        presc_nxt = '0;
      end
    endcase
  end

  // Simultaneous edge and pulse start cancel; saturate at 3
  always_comb begin
    pend_nxt = pend_q;
    if (rise && !take && (pend_q != 2'd3))
      pend_nxt = pend_q + 2'd1;
    else if (take && !rise)
      pend_nxt = pend_q - 2'd1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      st_q    <= COIN_IDLE;
      presc_q <= '0;
      ms_q    <= '0;
      pend_q  <= 2'd0;
      req_q   <= 1'b0;
    end else begin
      st_q    <= st_nxt;
      presc_q <= presc_nxt;
      ms_q    <= ms_nxt;
      pend_q  <= pend_nxt;
      req_q   <= req;
    end
  end

  assign coin = (st_q == COIN_PULSE);
  assign busy = (st_q != COIN_IDLE) || (pend_q != 2'd0);

endmodule

// File: rtl/arcade_input_conditioner.sv
// arcade_input_conditioner
// Keyboard/joystick front end for the SEGASYSTEM1 core: decodes PS/2 key
// events into held keys, merges them with both joysticks and produces the
// registered active-low INP0/INP1/INP2 bytes. Coin requests are shaped by
// coin_shaper.
//
// Ports:
//   clk_sys    in   system clock
//   reset      in   asynchronous active-high reset
//   ps2_key    in   [10] toggle, [9] pressed, [8:0] code
//   joystk1/2  in   [0]R [1]L [4]T1 [5]T2 [6]St1 [7]St2 [8]Coin
//   cabinet    in   0 = upright (P2 OR'd into P1), 1 = cocktail
//   inp0/inp1  out  ~{L,R,3'b0,T2,T1,1'b0} for P1/P2
//   inp2       out  ~{2'b0,St2,St1,3'b0,Coin}
//   coin_busy  out  coin shaper active or coins pending
//
// Build option: define INPUT_SOCD_EN to resolve L+R on one player to neither.
module arcade_input_conditioner
  import arcade_input_pkg::*;
#(
  parameter int CLK_KHZ = 48000,
  parameter int COIN_MS = 50,
  parameter int GAP_MS  = 80
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystk1,
  input  logic [15:0] joystk2,
  input  logic        cabinet,
  output logic [7:0]  inp0,
  output logic [7:0]  inp1,
  output logic [7:0]  inp2,
  output logic        coin_busy
);

  logic       tog_q;
  keys_t      keys_q;
  logic [8:0] code;
  logic       pressed;
  logic       key_evt;

  assign code    = ps2_key[8:0];
  assign pressed = ps2_key[9];
  assign key_evt = ps2_key[10] != tog_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tog_q  <= 1'b0;
      keys_q <= '0;
    end else begin
      tog_q <= ps2_key[10];
      if (key_evt) begin
        if (code[7:0] == PS2_UP)    keys_q.up    <= pressed;
        if (code[7:0] == PS2_DOWN)  keys_q.down  <= pressed;
        if (code[7:0] == PS2_LEFT)  keys_q.left  <= pressed;
        if (code[7:0] == PS2_RIGHT) keys_q.right <= pressed;
        if (code == PS2_T1)         keys_q.t1    <= pressed;
        if (code == PS2_T2)         keys_q.t2    <= pressed;
        if (code == PS2_F1)         keys_q.f1    <= pressed;
        if (code == PS2_F2)         keys_q.f2    <= pressed;
        if (code == PS2_ST1)        keys_q.st1   <= pressed;
        if (code == PS2_ST2)        keys_q.st2   <= pressed;
        if (code == PS2_COIN1)      keys_q.coin1 <= pressed;
        if (code == PS2_COIN2)      keys_q.coin2 <= pressed;
        if (code == PS2_L2)         keys_q.l2    <= pressed;
        if (code == PS2_R2)         keys_q.r2    <= pressed;
        if (code == PS2_T1_2)       keys_q.t1_2  <= pressed;
        if (code == PS2_T2_2)       keys_q.t2_2  <= pressed;
      end
    end
  end

  player_t p1_raw, p2_raw, p1, p2;
  logic    st1, st2, coin_req;

  always_comb begin
    p2_raw.l  = keys_q.l2   | joystk2[JOY_L];
    p2_raw.r  = keys_q.r2   | joystk2[JOY_R];
    p2_raw.t1 = keys_q.t1_2 | joystk2[JOY_T1];
    p2_raw.t2 = keys_q.t2_2 | joystk2[JOY_T2];

    p1_raw.l  = keys_q.left  | joystk1[JOY_L]  | (~cabinet & p2_raw.l);
    p1_raw.r  = keys_q.right | joystk1[JOY_R]  | (~cabinet & p2_raw.r);
    p1_raw.t1 = keys_q.t1    | joystk1[JOY_T1] | (~cabinet & p2_raw.t1);
    p1_raw.t2 = keys_q.t2    | joystk1[JOY_T2] | (~cabinet & p2_raw.t2);

    p1 = p1_raw;
    p2 = p2_raw;
`ifdef INPUT_SOCD_EN
    // Cleaned after the upright merge so P2's stick counts toward P1's L+R
    if (p1_raw.l && p1_raw.r) begin
      p1.l = 1'b0;
      p1.r = 1'b0;
    end
    if (p2_raw.l && p2_raw.r) begin
      p2.l = 1'b0;
      p2.r = 1'b0;
    end
`endif
  end

  assign st1 = keys_q.f1 | keys_q.st1 | joystk1[JOY_ST1] | joystk2[JOY_ST1];
  assign st2 = keys_q.f2 | keys_q.st2 | joystk1[JOY_ST2] | joystk2[JOY_ST2];
  assign coin_req = keys_q.f1 | keys_q.f2 | keys_q.coin1 | keys_q.coin2 |
                    joystk1[JOY_COIN] | joystk2[JOY_COIN];

  logic coin, busy;

  coin_shaper #(
    .CLK_KHZ (CLK_KHZ),
    .COIN_MS (COIN_MS),
    .GAP_MS  (GAP_MS)
  ) u_coin_shaper (
    .clk_sys (clk_sys),
    .reset   (reset),
    .req     (coin_req),
    .coin    (coin),
    .busy    (busy)
  );

  logic [7:0] sys_byte;

  always_comb begin
    sys_byte           = 8'hFF;
    sys_byte[INP_ST2]  = ~st2;
    sys_byte[INP_ST1]  = ~st1;
    sys_byte[INP_COIN] = ~coin;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      inp0      <= 8'hFF;
      inp1      <= 8'hFF;
      inp2      <= 8'hFF;
      coin_busy <= 1'b0;
    end else begin
      inp0      <= player_byte(p1);
      inp1      <= player_byte(p2);
      inp2      <= sys_byte;
      coin_busy <= busy;
    end
  end

  // Decoded or present but not part of the System 1 layout
  logic unused_inputs;
  assign unused_inputs = ^{keys_q.up, keys_q.down,
                           joystk1[15:9], joystk1[3:2],
                           joystk2[15:9], joystk2[3:2]};

endmodule

// File: tb/tb_arcade_input_conditioner.sv
module tb_arcade_input_conditioner;

  localparam int CLK_KHZ = 4;
  localparam int COIN_MS = 2;
  localparam int GAP_MS  = 3;
  localparam int PULSE_CYC = COIN_MS * CLK_KHZ;
  localparam int GAP_CYC   = GAP_MS * CLK_KHZ;

  localparam int K_UP = 0, K_DOWN = 1, K_LEFT = 2, K_RIGHT = 3, K_T1 = 4, K_T2 = 5;
  localparam int K_F1 = 6, K_F2 = 7, K_ST1 = 8, K_ST2 = 9, K_COIN1 = 10, K_COIN2 = 11;
  localparam int K_L2 = 12, K_R2 = 13, K_T1_2 = 14, K_T2_2 = 15;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystk1, joystk2;
  logic        cabinet;
  logic [7:0]  inp0, inp1, inp2;
  logic        coin_busy;

  always #5 clk_sys = ~clk_sys;

  arcade_input_conditioner #(
    .CLK_KHZ (CLK_KHZ),
    .COIN_MS (COIN_MS),
    .GAP_MS  (GAP_MS)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_key   (ps2_key),
    .joystk1   (joystk1),
    .joystk2   (joystk2),
    .cabinet   (cabinet),
    .inp0      (inp0),
    .inp1      (inp1),
    .inp2      (inp2),
    .coin_busy (coin_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit held [16];
  bit tog_m;

  function automatic int key_index(input logic [8:0] c);
    case (c[7:0])
      8'h75: return K_UP;
      8'h72: return K_DOWN;
      8'h6B: return K_LEFT;
      8'h74: return K_RIGHT;
      default: ;
    endcase
    case (c)
      9'h029: return K_T1;
      9'h014: return K_T2;
      9'h005: return K_F1;
      9'h006: return K_F2;
      9'h016: return K_ST1;
      9'h01E: return K_ST2;
      9'h02E: return K_COIN1;
      9'h036: return K_COIN2;
      9'h023: return K_L2;
      9'h034: return K_R2;
      9'h01C: return K_T1_2;
      9'h01B: return K_T2_2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] pbyte(input bit l, input bit r, input bit t2, input bit t1);
    return ~{l, r, 3'b000, t2, t1, 1'b0};
  endfunction

  task automatic model(output logic [7:0] e0, output logic [7:0] e1, output logic [7:0] e2);
    bit l1, r1, a1, b1, l2, r2, a2, b2, s1, s2;
    l2 = held[K_L2]   | joystk2[1];
    r2 = held[K_R2]   | joystk2[0];
    a2 = held[K_T1_2] | joystk2[4];
    b2 = held[K_T2_2] | joystk2[5];
    l1 = held[K_LEFT]  | joystk1[1] | (!cabinet && l2);
    r1 = held[K_RIGHT] | joystk1[0] | (!cabinet && r2);
    a1 = held[K_T1]    | joystk1[4] | (!cabinet && a2);
    b1 = held[K_T2]    | joystk1[5] | (!cabinet && b2);
`ifdef INPUT_SOCD_EN
    if (l1 && r1) begin l1 = 0; r1 = 0; end
    if (l2 && r2) begin l2 = 0; r2 = 0; end
`endif
    s1 = held[K_F1] | held[K_ST1] | joystk1[6] | joystk2[6];
    s2 = held[K_F2] | held[K_ST2] | joystk1[7] | joystk2[7];
    e0 = pbyte(l1, r1, b1, a1);
    e1 = pbyte(l2, r2, b2, a2);
    e2 = ~{2'b00, s2, s1, 4'b0000};
  endtask

  // Drives one PS/2 word at the current (negedge) instant and updates the model
  task automatic send_key(input logic [8:0] c, input bit pr, input bit do_toggle);
    logic t;
    int   k;
    t = do_toggle ? ~ps2_key[10] : ps2_key[10];
    ps2_key = {t, pr, c};
    if (t != tog_m) begin
      k = key_index(c);
      if (k >= 0) held[k] = pr;
    end
    tog_m = t;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    ps2_key = '0; joystk1 = '0; joystk2 = '0;
    reset = 1'b1;
    foreach (held[i]) held[i] = 0;
    tog_m = 0;
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  // ---------------- coin trace capture ----------------
  bit c_tr [0:199];
  bit b_tr [0:199];
  int starts[$];
  int ends[$];

  // mode 0: request held for 100 cycles; mode 1: five 1-cycle requests, 2 apart
  task automatic run_coin(input int mode, input int ncyc, input bit use_p2);
    bit rq;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk_sys);
      c_tr[i] = inp2[0];
      b_tr[i] = coin_busy;
      rq = (mode == 0) ? (i < 100) : (i < 10 && (i % 2) == 0);
      if (use_p2) joystk2[8] = rq; else joystk1[8] = rq;
    end
    starts.delete();
    ends.delete();
    for (int i = 1; i < ncyc; i++) begin
      if (c_tr[i-1] && !c_tr[i]) starts.push_back(i);
      if (!c_tr[i-1] && c_tr[i]) ends.push_back(i);
    end
  endtask

  function automatic int busy_lag(input int from, input int ncyc);
    for (int i = from; i < ncyc; i++)
      if (!b_tr[i]) return i - from;
    return -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] e0, e1, e2;
    logic [8:0] pool [20];
    logic [1:0] socd_exp;
    int exp_pulses, n, lag;
    bit sel;

    pool = '{9'h075, 9'h172, 9'h06B, 9'h16B, 9'h074, 9'h029, 9'h014, 9'h016,
             9'h01E, 9'h023, 9'h034, 9'h01C, 9'h01B, 9'h005, 9'h006, 9'h02E,
             9'h036, 9'h129, 9'h11C, 9'h055};

    reset = 1'b1; ps2_key = '0; joystk1 = '0; joystk2 = '0; cabinet = 1'b0;
    foreach (held[i]) held[i] = 0;
    tog_m = 0;
    repeat (3) @(negedge clk_sys);
    check("rst_inp0", inp0, 8'hFF);
    check("rst_inp1", inp1, 8'hFF);
    check("rst_inp2", inp2, 8'hFF);
    check("rst_busy", coin_busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("idle_inp0", inp0, 8'hFF);
    check("idle_inp1", inp1, 8'hFF);
    check("idle_inp2", inp2, 8'hFF);
    check("idle_busy", coin_busy, 0);

    // Joystick path: one cycle latency
    joystk1 = 16'h0011;
    @(negedge clk_sys);
    check("joy_r_t1", inp0, 8'hBD);
    joystk2 = 16'h0002;
    @(negedge clk_sys);
    model(e0, e1, e2);
    check("upright_p2_into_p1", inp0, e0);
    cabinet = 1'b1;
    @(negedge clk_sys);
    check("cocktail_inp1", inp1, 8'h7F);
    check("cocktail_inp0", inp0, 8'hBD);
    joystk1 = '0; joystk2 = '0;
    @(negedge clk_sys);

    // Key path: two cycle latency, toggle-driven
    send_key(9'h029, 1, 1);
    @(negedge clk_sys);
    check("key_lat1", inp0, 8'hFF);
    @(negedge clk_sys);
    check("key_t1_press", inp0, 8'hFD);
    send_key(9'h029, 0, 0);
    repeat (2) @(negedge clk_sys);
    check("key_no_toggle", inp0, 8'hFD);
    send_key(9'h029, 0, 1);
    repeat (2) @(negedge clk_sys);
    check("key_t1_release", inp0, 8'hFF);

    // L+R on one stick
    joystk1 = 16'h0003;
    @(negedge clk_sys);
`ifdef INPUT_SOCD_EN
    socd_exp = 2'b11;
`else
    socd_exp = 2'b00;
`endif
    check("socd_lr", inp0[7:6], socd_exp);
    joystk1 = '0;

    // Randomized merge/decode against the model (coin bit masked)
    for (int it = 0; it < 150; it++) begin
      @(negedge clk_sys);
      cabinet = $urandom_range(0, 1);
      joystk1 = 16'($urandom) & ~16'h0100;
      joystk2 = 16'($urandom) & ~16'h0100;
      if ($urandom_range(0, 1) == 1)
        send_key(pool[$urandom_range(0, 19)], $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) != 0);
      repeat (2) @(negedge clk_sys);
      model(e0, e1, e2);
      check("rand_inp0", inp0, e0);
      check("rand_inp1", inp1, e1);
      check("rand_inp2", inp2 & 8'hFE, e2 & 8'hFE);
    end

    // Coin: held request gives one pulse
    do_reset();
    check("coin_pre_busy", coin_busy, 0);
    sel = $urandom_range(0, 1) == 1;
    run_coin(0, 150, sel);
    check("hold_pulses", starts.size(), 1);
    check("hold_ends", ends.size(), 1);
    if (ends.size() >= 1 && starts.size() >= 1) begin
      check("hold_width", ends[0] - starts[0], PULSE_CYC);
      check("hold_busy_in_pulse", b_tr[starts[0]], 1);
      lag = busy_lag(ends[0], 150);
      check("hold_busy_lag", lag, GAP_CYC);
    end

    // Coin: five quick requests, queue saturates at 3 behind the first
    do_reset();
    sel = $urandom_range(0, 1) == 1;
    run_coin(1, 150, sel);
    exp_pulses = 1 + ((5 - 1) < 3 ? (5 - 1) : 3);
    check("burst_pulses", starts.size(), exp_pulses);
    check("burst_ends", ends.size(), exp_pulses);
    n = (starts.size() < ends.size()) ? starts.size() : ends.size();
    for (int i = 0; i < n; i++)
      check($sformatf("burst_width%0d", i), ends[i] - starts[i], PULSE_CYC);
    for (int i = 1; i < n; i++)
      check($sformatf("burst_gap%0d", i), starts[i] - ends[i-1], GAP_CYC);
    if (n >= 1) begin
      lag = busy_lag(ends[n-1], 150);
      check("burst_busy_lag", lag, GAP_CYC);
    end

    // Coin: reset during the second pulse drops everything
    do_reset();
    begin
      bit prev, found;
      int seen, after;
      prev = 1; found = 0; seen = 0; after = 0;
      for (int i = 0; i < 200 && !found; i++) begin
        @(negedge clk_sys);
        if (prev && !inp2[0]) seen++;
        prev = inp2[0];
        joystk1[8] = (i < 10 && (i % 2) == 0);
        if (seen == 2) begin
          after++;
          if (after == 3) found = 1;
        end
      end
      check("rstmid_second_seen", found, 1);
      @(negedge clk_sys);
      check("rstmid_in_pulse", inp2[0], 0);
      reset = 1'b1;
      joystk1 = '0;
      #1;
      check("rstmid_inp2", inp2, 8'hFF);
      check("rstmid_busy", coin_busy, 0);
      @(negedge clk_sys);
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_sys);
        c_tr[i] = inp2[0];
        b_tr[i] = coin_busy;
      end
      seen = 0;
      for (int i = 0; i < 100; i++) if (!c_tr[i] || b_tr[i]) seen++;
      check("rstmid_no_more", seen, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
